// File: rtl/elevator_pkg.sv
// Shared types and defaults for the SCAN elevator controller.
package elevator_pkg;

  localparam int unsigned MAX_FLOORS       = 16;
  localparam int unsigned MAX_FLOOR_W      = 4;
  localparam int unsigned DEF_FLOOR_CYCLES = 10_000_000;
  localparam int unsigned DEF_DOOR_CYCLES  = 30_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // One-hot floor mask sized for the largest supported building.
  function automatic logic [MAX_FLOORS-1:0] floor_mask(input logic [MAX_FLOOR_W-1:0] f);
    return MAX_FLOORS'(1) << f;
  endfunction

endpackage

// File: rtl/elevator_scan_controller_if.sv
// Call-button inputs and car status outputs of the elevator controller.
interface elevator_scan_controller_if #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
);

  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic                  arrived;

  modport master (
    output call_req,
    input  current_floor, pending, moving, dir_up, door_open, arrived
  );

  modport slave (
    input  call_req,
    output current_floor, pending, moving, dir_up, door_open, arrived
  );

endinterface

// File: rtl/elevator_call_latch.sv
// Pending-call bitmap with serve/door clearing and above/below reductions.
module elevator_call_latch
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic                  hold_en,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above_c,
  output logic                  below_c
);

  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] clr_mask, hold_mask, le_mask, lt_mask;

  // Served floor and the open-door floor both win over a same-edge call.
  always_comb begin
    clr_mask  = clr_en  ? NUM_FLOORS'(floor_mask(MAX_FLOOR_W'(clr_floor))) : '0;
    hold_mask = hold_en ? NUM_FLOORS'(floor_mask(MAX_FLOOR_W'(floor)))     : '0;
    pending_d = (pending_q | call_req) & ~clr_mask & ~hold_mask;
  end

  // le_mask overflows to all-ones at the top floor, leaving nothing above.
  always_comb begin
    le_mask = (NUM_FLOORS'(2) << floor) - NUM_FLOORS'(1);
    lt_mask = (NUM_FLOORS'(1) << floor) - NUM_FLOORS'(1);
    above_c = |(pending_q & ~le_mask);
    below_c = |(pending_q & lt_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator controller: FSM, travel/door timer and floor counter.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = 8,
  parameter int unsigned FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int unsigned FLOOR_CYCLES = DEF_FLOOR_CYCLES,
  parameter int unsigned DOOR_CYCLES  = DEF_DOOR_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  elevator_scan_controller_if.slave   bus
);

  localparam int unsigned MAX_CYCLES = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] FLOOR_LOAD = TIMER_W'(FLOOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_CYCLES - 1);

  state_t                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, step_floor, clr_floor;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  dir_up_q, dir_up_d;
  logic                  arrived_q, arrived_d;
  logic                  moving_q, moving_d;
  logic                  door_open_q, door_open_d;
  logic                  clr_en, hold_en, step_up, ahead, behind;
  logic                  above_c, below_c;
  logic [NUM_FLOORS-1:0] pending;

  elevator_call_latch #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_latch (
    .clk       (clk),
    .reset     (reset),
    .call_req  (bus.call_req),
    .floor     (floor_q),
    .clr_en    (clr_en),
    .clr_floor (clr_floor),
    .hold_en   (hold_en),
    .pending   (pending),
    .above_c   (above_c),
    .below_c   (below_c)
  );

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    timer_d    = timer_q;
    arrived_d  = 1'b0;
    clr_en     = 1'b0;
    clr_floor  = floor_q;
    hold_en    = (state_q == DOOR_OPEN);
    step_up    = (state_q == MOVE_UP);
    step_floor = step_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    ahead      = dir_up_q ? above_c : below_c;
    behind     = dir_up_q ? below_c : above_c;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pending[floor_q]) begin
          state_d   = DOOR_OPEN;
          clr_en    = 1'b1;
          timer_d   = DOOR_LOAD;
          arrived_d = 1'b1;
        end else if (above_c && (dir_up_q || !below_c)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
          timer_d  = FLOOR_LOAD;
        end else if (below_c) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
          timer_d  = FLOOR_LOAD;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else begin
          floor_d = step_floor;
          timer_d = FLOOR_LOAD;
          if (pending[step_floor]) begin
            state_d   = DOOR_OPEN;
            clr_en    = 1'b1;
            clr_floor = step_floor;
            timer_d   = DOOR_LOAD;
            arrived_d = 1'b1;
          // New floor is not pending, so calls beyond it equal calls beyond the old floor.
          end else if (!(step_up ? above_c : below_c)) begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
      end

      DOOR_OPEN: begin
        if (bus.call_req[floor_q]) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (ahead) begin
          state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
          timer_d = FLOOR_LOAD;
        end else if (behind) begin
          state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
          dir_up_d = !dir_up_q;
          timer_d  = FLOOR_LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    moving_d    = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    door_open_d = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      timer_q     <= '0;
      arrived_q   <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      timer_q     <= timer_d;
      arrived_q   <= arrived_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign bus.current_floor = floor_q;
  assign bus.pending       = pending;
  assign bus.moving        = moving_q;
  assign bus.dir_up        = dir_up_q;
  assign bus.door_open     = door_open_q;
  assign bus.arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed scenarios plus random calls, checked against a behavioural elevator model.
module tb_elevator_scan_controller;

  localparam int NF      = 8;
  localparam int FLOOR_C = 4;
  localparam int DOOR_C  = 3;

  logic clk;
  logic reset;

  elevator_scan_controller_if #(.NUM_FLOORS(NF)) bus ();

  elevator_scan_controller #(
    .NUM_FLOORS   (NF),
    .FLOOR_CYCLES (FLOOR_C),
    .DOOR_CYCLES  (DOOR_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "init";
  int    arr_log[$];

  // Model state: floor, pending set, direction, activity flags, cycles remaining.
  bit [NF-1:0] mp;
  int          mf;
  bit          mdir, mmov, mdoor, marr;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic bit any_above(input int f);
    for (int i = f + 1; i < NF; i++) if (mp[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input int f);
    for (int i = 0; i < f; i++) if (mp[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mp = '0; mf = 0; mdir = 1'b1; mmov = 1'b0; mdoor = 1'b0; mcnt = 0; marr = 1'b0;
  endtask

  task automatic model_edge(input logic [NF-1:0] req);
    bit [NF-1:0] np;
    bit ab, be, door0;
    int served, f0;
    ab = any_above(mf); be = any_below(mf);
    served = -1; f0 = mf; door0 = mdoor; marr = 1'b0;
    if (mdoor) begin
      if (req[mf]) mcnt = DOOR_C;
      else begin
        mcnt--;
        if (mcnt == 0) begin
          mdoor = 1'b0;
          if (mdir ? ab : be) begin mmov = 1'b1; mcnt = FLOOR_C; end
          else if (mdir ? be : ab) begin mmov = 1'b1; mdir = !mdir; mcnt = FLOOR_C; end
        end
      end
    end else if (mmov) begin
      mcnt--;
      if (mcnt == 0) begin
        mf = mdir ? mf + 1 : mf - 1;
        if (mp[mf]) begin
          mmov = 1'b0; mdoor = 1'b1; mcnt = DOOR_C; served = mf; marr = 1'b1;
        end else begin
          mcnt = FLOOR_C;
          if (!(mdir ? any_above(mf) : any_below(mf))) mmov = 1'b0;
        end
      end
    end else begin
      if (mp[mf]) begin
        mdoor = 1'b1; mcnt = DOOR_C; served = mf; marr = 1'b1;
      end else if (ab && (mdir || !be)) begin
        mmov = 1'b1; mdir = 1'b1; mcnt = FLOOR_C;
      end else if (be) begin
        mmov = 1'b1; mdir = 1'b0; mcnt = FLOOR_C;
      end
    end
    np = mp | req;
    if (served >= 0) np[served] = 1'b0;
    if (door0) np[f0] = 1'b0;
    mp = np;
  endtask

  task automatic cmp_model();
    chk("floor",     32'(bus.current_floor), 32'(mf));
    chk("pending",   32'(bus.pending),       32'(mp));
    chk("moving",    32'(bus.moving),        32'(mmov));
    chk("dir_up",    32'(bus.dir_up),        32'(mdir));
    chk("door_open", 32'(bus.door_open),     32'(mdoor));
    chk("arrived",   32'(bus.arrived),       32'(marr));
  endtask

  // Drive one cycle of calls, advance the model on the edge, compare just after it.
  task automatic tick(input logic [NF-1:0] req);
    bus.call_req = req;
    @(posedge clk);
    model_edge(req);
    #1;
    cmp_model();
    if (bus.arrived === 1'b1) arr_log.push_back(int'(bus.current_floor));
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    while (!(bus.moving === 1'b0 && bus.door_open === 1'b0 && bus.pending === '0) && n < maxc) begin
      tick('0);
      n++;
    end
    chk("idle_timeout", 32'(n < maxc), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_floor"},   32'(bus.current_floor), 32'd0);
    chk({tag, "_pending"}, 32'(bus.pending),       32'd0);
    chk({tag, "_dir_up"},  32'(bus.dir_up),        32'd1);
    chk({tag, "_moving"},  32'(bus.moving),        32'd0);
    chk({tag, "_door"},    32'(bus.door_open),     32'd0);
    chk({tag, "_arrived"}, 32'(bus.arrived),       32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, prev, wrong, maxf;
    int exp3[3];
    logic [NF-1:0] req;
    int r;

    // Reset and idle hold.
    phase = "reset";
    reset = 1'b1;
    bus.call_req = '0;
    model_reset();
    #7;
    check_reset_outputs("in_reset");
    #3;
    reset = 1'b0;
    repeat (3) tick('0);
    check_reset_outputs("idle_hold");

    // Single call to floor 3: exact step and door timing.
    phase = "call3";
    tick(8'h08);
    chk("e0_pending", 32'(bus.pending), 32'h08);
    chk("e0_moving",  32'(bus.moving),  32'd0);
    for (int e = 1; e <= 16; e++) begin
      tick('0);
      if (e == 1)  chk("e1_moving", 32'(bus.moving), 32'd1);
      if (e == 4)  chk("e4_floor",  32'(bus.current_floor), 32'd0);
      if (e == 5)  chk("e5_floor",  32'(bus.current_floor), 32'd1);
      if (e == 9)  chk("e9_floor",  32'(bus.current_floor), 32'd2);
      if (e == 13) begin
        chk("e13_floor",   32'(bus.current_floor), 32'd3);
        chk("e13_arrived", 32'(bus.arrived),       32'd1);
        chk("e13_door",    32'(bus.door_open),     32'd1);
        chk("e13_pending", 32'(bus.pending),       32'd0);
      end
      if (e == 14) chk("e14_arrived", 32'(bus.arrived),   32'd0);
      if (e == 15) chk("e15_door",    32'(bus.door_open), 32'd1);
      if (e == 16) begin
        chk("e16_door",   32'(bus.door_open), 32'd0);
        chk("e16_moving", 32'(bus.moving),    32'd0);
      end
    end

    // Asynchronous reset while travelling down through floor 2.
    phase = "midreset";
    tick(8'h01);
    n = 0;
    while (!(bus.current_floor === 3'd2 && bus.moving === 1'b1) && n < 40) begin
      tick('0);
      n++;
    end
    chk("reach2_timeout", 32'(n < 40), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Collective order: 2 then 5 going up, then reverse to 1.
    phase = "scan";
    arr_log.delete();
    tick(8'h24);
    n = 0;
    while (!(bus.door_open === 1'b1 && bus.current_floor === 3'd2) && n < 100) begin
      tick('0);
      n++;
    end
    chk("door2_timeout", 32'(n < 100), 32'd1);
    tick(8'h02);
    run_until_idle(300);
    exp3 = '{2, 5, 1};
    chk("stop_count", 32'(arr_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("stop_order", (i < arr_log.size()) ? 32'(arr_log[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));
    chk("scan_dir", 32'(bus.dir_up), 32'd0);

    // Own-floor call opens door with no move; repeat call extends dwell.
    phase = "own_floor";
    tick(8'h01);
    run_until_idle(100);
    chk("at0", 32'(bus.current_floor), 32'd0);
    tick(8'h01);
    tick('0);
    chk("e1_door",    32'(bus.door_open), 32'd1);
    chk("e1_arrived", 32'(bus.arrived),   32'd1);
    chk("e1_moving",  32'(bus.moving),    32'd0);
    tick('0);
    tick(8'h01);
    chk("reload_pending", 32'(bus.pending), 32'd0);
    tick('0);
    chk("e4_door", 32'(bus.door_open), 32'd1);
    tick('0);
    chk("e5_door", 32'(bus.door_open), 32'd1);
    tick('0);
    chk("e6_door", 32'(bus.door_open), 32'd0);
    chk("e6_floor", 32'(bus.current_floor), 32'd0);

    // Full travel to the top and back to the bottom without wrapping.
    phase = "extremes";
    tick(8'h80);
    n = 0; wrong = 0; maxf = 0;
    while (!(bus.moving === 1'b0 && bus.door_open === 1'b0 && bus.pending === '0) && n < 200) begin
      prev = int'(bus.current_floor);
      tick('0);
      if (int'(bus.current_floor) != prev && int'(bus.current_floor) != prev + 1) wrong++;
      if (int'(bus.current_floor) > maxf) maxf = int'(bus.current_floor);
      n++;
    end
    chk("up_timeout", 32'(n < 200), 32'd1);
    chk("up_floor",   32'(bus.current_floor), 32'd7);
    chk("up_max",     32'(maxf), 32'd7);
    chk("up_steps",   32'(wrong), 32'd0);
    tick(8'h01);
    n = 0; wrong = 0;
    while (!(bus.moving === 1'b0 && bus.door_open === 1'b0 && bus.pending === '0) && n < 200) begin
      prev = int'(bus.current_floor);
      tick('0);
      if (int'(bus.current_floor) != prev && int'(bus.current_floor) != prev - 1) wrong++;
      n++;
    end
    chk("down_timeout", 32'(n < 200), 32'd1);
    chk("down_floor",   32'(bus.current_floor), 32'd0);
    chk("down_steps",   32'(wrong), 32'd0);

    // Repeat call on the arrival edge is absorbed by the serve.
    phase = "arrive_edge";
    arr_log.delete();
    tick(8'h10);
    n = 0;
    while (!(mmov && mdir && mcnt == 1 && mf == 3) && n < 100) begin
      tick('0);
      n++;
    end
    chk("approach_timeout", 32'(n < 100), 32'd1);
    tick(8'h10);
    chk("arr_floor",   32'(bus.current_floor), 32'd4);
    chk("arr_pulse",   32'(bus.arrived),       32'd1);
    chk("arr_pending", 32'(bus.pending),       32'd0);
    run_until_idle(100);
    chk("p4_after", 32'(bus.pending[4]), 32'd0);
    chk("served_once", 32'(arr_log.size()), 32'd1);

    // Random call traffic against the model.
    phase = "random";
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      req = NF'($urandom);
      else if (r < 3)  req = NF'(1) << $urandom_range(0, NF - 1);
      else             req = '0;
      tick(req);
    end
    run_until_idle(2000);
    chk("final_pending", 32'(bus.pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
